// File: rtl/softmax_exp_scheduler.sv
// Softmax COMPUTE-stage sequencer: buffers one vector, drives the exp unit one
// element at a time, forwards each result and presents the saturating sum.
module softmax_exp_scheduler #(
   parameter int data_size      = 32,
   parameter int number_of_data = 10,
   parameter int sum_size       = 40,
   parameter int timeout_cycles = 64
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [data_size-1:0]  data_i,
   input  logic                  data_valid_i,
   output logic                  ready_o,
   output logic [data_size-1:0]  exp_data_o,
   output logic                  exp_data_valid_o,
   input  logic [data_size-1:0]  exp_result_i,
   input  logic                  exp_result_valid_i,
   output logic [data_size-1:0]  result_o,
   output logic                  result_valid_o,
   output logic [sum_size-1:0]   sum_o,
   output logic                  sum_valid_o,
   output logic                  busy_o,
   output logic                  error_o
);

   localparam int CW = (number_of_data > 1) ? $clog2(number_of_data) : 1;
   localparam logic [CW-1:0] LAST = CW'(number_of_data - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t               state;
   logic [CW-1:0]        wr_cnt;
   logic [CW-1:0]        rd_cnt;
   logic [7:0]           timer;
   logic [8:0]           timer_nxt;
   logic [sum_size-1:0]  acc;
   logic [sum_size:0]    acc_sum;
   logic [sum_size-1:0]  acc_nxt;
   logic [data_size-1:0] buffer [number_of_data];

   // Extra carry bit detects overflow so the sum clamps instead of wrapping.
   assign acc_sum   = {1'b0, acc} + {{(sum_size + 1 - data_size){1'b0}}, exp_result_i};
   assign acc_nxt   = acc_sum[sum_size] ? {sum_size{1'b1}} : acc_sum[sum_size-1:0];
   assign timer_nxt = {1'b0, timer} + 9'd1;

   always_ff @(posedge clock_i) begin
      if (state == S_LOAD && data_valid_i)
         buffer[wr_cnt] <= data_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state            <= S_IDLE;
         wr_cnt           <= '0;
         rd_cnt           <= '0;
         timer            <= '0;
         acc              <= '0;
         ready_o          <= 1'b0;
         exp_data_o       <= '0;
         exp_data_valid_o <= 1'b0;
         result_o         <= '0;
         result_valid_o   <= 1'b0;
         sum_o            <= '0;
         sum_valid_o      <= 1'b0;
         busy_o           <= 1'b0;
         error_o          <= 1'b0;
      end else begin
         exp_data_valid_o <= 1'b0;
         result_valid_o   <= 1'b0;
         sum_valid_o      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state   <= S_LOAD;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b1;
                  wr_cnt  <= '0;
                  rd_cnt  <= '0;
                  acc     <= '0;
                  sum_o   <= '0;
                  error_o <= 1'b0;
               end
            end
            S_LOAD: begin
               if (data_valid_i) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST) begin
                     state   <= S_ISSUE;
                     ready_o <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               exp_data_o       <= buffer[rd_cnt];
               exp_data_valid_o <= 1'b1;
               timer            <= '0;
               state            <= S_WAIT;
            end
            S_WAIT: begin
               // A result landing on the final watchdog cycle still wins.
               if (exp_result_valid_i) begin
                  result_o       <= exp_result_i;
                  result_valid_o <= 1'b1;
                  acc            <= acc_nxt;
                  rd_cnt         <= rd_cnt + 1'b1;
                  state          <= (rd_cnt == LAST) ? S_DONE : S_ISSUE;
               end else if (timer_nxt == 9'(timeout_cycles)) begin
                  error_o <= 1'b1;
                  busy_o  <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  timer <= timer_nxt[7:0];
               end
            end
            S_DONE: begin
               sum_o       <= acc;
               sum_valid_o <= 1'b1;
               busy_o      <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_exp_scheduler.sv
// Directed bench for softmax_exp_scheduler with a latency-programmable exp stub.
module tb_softmax_exp_scheduler;

   localparam int DW = 32;
   localparam int N  = 10;
   localparam int SW = 33;
   localparam int TO = 64;

   logic          clock_i = 1'b0;
   logic          reset_i, start_i, data_valid_i;
   logic [DW-1:0] data_i;
   logic          ready_o, exp_data_valid_o, result_valid_o, sum_valid_o, busy_o, error_o;
   logic [DW-1:0] exp_data_o, result_o;
   logic [SW-1:0] sum_o;
   logic          exp_result_valid_i;
   logic [DW-1:0] exp_result_i;

   logic          stub_v = 1'b0;
   logic [DW-1:0] stub_d = '0;
   logic          spur_v = 1'b0;
   logic [DW-1:0] spur_d = '0;
   assign exp_result_valid_i = stub_v | spur_v;
   assign exp_result_i       = spur_v ? spur_d : stub_d;

   always #5 clock_i = ~clock_i;

   softmax_exp_scheduler #(
      .data_size(DW), .number_of_data(N), .sum_size(SW), .timeout_cycles(TO)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
      .data_i(data_i), .data_valid_i(data_valid_i), .ready_o(ready_o),
      .exp_data_o(exp_data_o), .exp_data_valid_o(exp_data_valid_o),
      .exp_result_i(exp_result_i), .exp_result_valid_i(exp_result_valid_i),
      .result_o(result_o), .result_valid_o(result_valid_o),
      .sum_o(sum_o), .sum_valid_o(sum_valid_o),
      .busy_o(busy_o), .error_o(error_o)
   );

   int checks = 0;
   int errors = 0;

   // exp stub: answers issue k with operand+100 (or all-ones) after stub_lat edges
   int            stub_lat   = 3;
   int            stub_stop  = 1000;
   bit            stub_fixed = 1'b0;
   int            stub_cnt   = 0;
   int            pend       = 0;
   logic [DW-1:0] pend_val   = '0;

   always @(negedge clock_i) begin
      stub_v = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin stub_v = 1'b1; stub_d = pend_val; end
      end
      if (exp_data_valid_o === 1'b1 && stub_cnt < stub_stop) begin
         stub_cnt++;
         pend_val = stub_fixed ? 32'hFFFF_FFFF : exp_data_o + 32'd100;
         if (stub_lat <= 1) begin stub_v = 1'b1; stub_d = pend_val; pend = 0; end
         else pend = stub_lat - 1;
      end
   end

   // monitor
   int            cyc = 0;
   int            n_sum = 0;
   int            sum_cyc = 0;
   int            err_cyc = -1;
   int            last_issue_cyc = 0;
   logic          err_d = 1'b0;
   logic [SW-1:0] last_sum = '0;
   logic [DW-1:0] iss_q[$];
   logic [DW-1:0] res_q[$];

   always @(negedge clock_i) begin
      cyc++;
      if (exp_data_valid_o === 1'b1) begin iss_q.push_back(exp_data_o); last_issue_cyc = cyc; end
      if (result_valid_o === 1'b1) res_q.push_back(result_o);
      if (sum_valid_o === 1'b1) begin n_sum++; last_sum = sum_o; sum_cyc = cyc; end
      if (error_o === 1'b1 && err_d !== 1'b1) err_cyc = cyc;
      err_d = error_o;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock_i);
      #1;
   endtask

   task automatic run_vector(input int base, input bit gaps);
      int k = 0;
      bit ph = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      while (k < N) begin
         if (gaps && ph) begin data_valid_i = 1'b0; data_i = 32'hDEAD; end
         else begin data_valid_i = 1'b1; data_i = DW'(base + k); k++; end
         ph = ~ph;
         tick();
      end
      data_valid_i = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         tick();
         if (sum_valid_o === 1'b1) begin ok = 1'b1; break; end
         if (error_o === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
      tick(3);
      checks++;
      if ({ready_o, busy_o, error_o, exp_data_valid_o, result_valid_o, sum_valid_o} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 000000",
            {ready_o, busy_o, error_o, exp_data_valid_o, result_valid_o, sum_valid_o});
      end
      checks++;
      if (sum_o !== '0 || result_o !== '0 || exp_data_o !== '0) begin
         errors++; $display("FAIL reset_data: got sum %0h res %0h exp %0h expected 0", sum_o, result_o, exp_data_o);
      end
      reset_i = 1'b0;
      tick(2);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy got %b expected 0", busy_o); end
   endtask

   task automatic test_basic();
      int r0 = res_q.size();
      int s0 = iss_q.size();
      int n0 = n_sum;
      int c0 = cyc;
      bit ok;
      logic [DW-1:0] ev;
      stub_lat = 3; stub_stop = stub_cnt + 1000;
      run_vector(1, 1'b0);
      checks++;
      if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
         errors++; $display("FAIL basic_after_load: busy/ready got %b%b expected 10", busy_o, ready_o);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_done: no sum_valid_o within bound"); end
      checks++;
      if (res_q.size() - r0 != N || iss_q.size() - s0 != N) begin
         errors++; $display("FAIL basic_counts: results %0d issues %0d expected %0d", res_q.size() - r0, iss_q.size() - s0, N);
      end
      for (int i = 0; i < N; i++) begin
         ev = DW'(101 + i);
         checks++;
         if (res_q[r0 + i] !== ev) begin errors++; $display("FAIL basic_result[%0d]: got %0d expected %0d", i, res_q[r0 + i], ev); end
      end
      checks++;
      if (last_sum !== 33'd1055) begin errors++; $display("FAIL basic_sum: got %0d expected 1055", last_sum); end
      checks++;
      if (sum_cyc - c0 != 52) begin errors++; $display("FAIL basic_latency: got %0d expected 52", sum_cyc - c0); end
      tick(2);
      checks++;
      if (n_sum - n0 != 1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL basic_single_sum: sum pulses %0d busy %b expected 1 and 0", n_sum - n0, busy_o);
      end
   endtask

   task automatic test_gapped_load();
      int s0 = iss_q.size();
      bit ok;
      logic [DW-1:0] ev;
      data_valid_i = 1'b1; data_i = 32'd99;
      tick(3);
      run_vector(11, 1'b1);
      wait_done(ok);
      checks++;
      if (!ok || iss_q.size() - s0 != N) begin
         errors++; $display("FAIL gap_done: ok %b issues %0d expected 1 and %0d", ok, iss_q.size() - s0, N);
      end
      for (int i = 0; i < N; i++) begin
         ev = DW'(11 + i);
         checks++;
         if (iss_q[s0 + i] !== ev) begin errors++; $display("FAIL gap_operand[%0d]: got %0d expected %0d", i, iss_q[s0 + i], ev); end
      end
      checks++;
      if (last_sum !== 33'd1155) begin errors++; $display("FAIL gap_sum: got %0d expected 1155", last_sum); end
      tick(2);
   endtask

   task automatic test_timeout();
      int r0 = res_q.size();
      int s0 = iss_q.size();
      int n0 = n_sum;
      bit ok;
      stub_lat = 3; stub_stop = stub_cnt + 4;
      run_vector(1, 1'b0);
      wait_done(ok);
      checks++;
      if (ok || error_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL timeout_abort: ok %b error %b busy %b expected 0 1 0", ok, error_o, busy_o);
      end
      checks++;
      if (err_cyc - last_issue_cyc != TO) begin
         errors++; $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - last_issue_cyc, TO);
      end
      checks++;
      if (res_q.size() - r0 != 4 || iss_q.size() - s0 != 5 || n_sum != n0) begin
         errors++; $display("FAIL timeout_partial: results %0d issues %0d sums %0d expected 4 5 0",
            res_q.size() - r0, iss_q.size() - s0, n_sum - n0);
      end
      tick(3);
      checks++;
      if (error_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", error_o); end
      stub_stop = stub_cnt + 1000;
      run_vector(21, 1'b0);
      checks++;
      if (error_o !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", error_o); end
      wait_done(ok);
      checks++;
      if (!ok || last_sum !== 33'd1255) begin errors++; $display("FAIL timeout_recover: ok %b sum %0d expected 1 1255", ok, last_sum); end
      tick(2);
   endtask

   task automatic test_timeout_boundary();
      int r0 = res_q.size();
      bit ok;
      stub_lat = TO; stub_stop = stub_cnt + 1000;
      run_vector(1, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || error_o !== 1'b0) begin errors++; $display("FAIL boundary_accept: ok %b error %b expected 1 0", ok, error_o); end
      checks++;
      if (last_sum !== 33'd1055 || res_q.size() - r0 != N) begin
         errors++; $display("FAIL boundary_sum: sum %0d results %0d expected 1055 %0d", last_sum, res_q.size() - r0, N);
      end
      tick(2);
   endtask

   task automatic test_saturation();
      int r0 = res_q.size();
      bit ok;
      stub_lat = 2; stub_fixed = 1'b1;
      run_vector(1, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || last_sum !== 33'h1_FFFF_FFFF) begin errors++; $display("FAIL sat_sum: ok %b sum %0h expected 1 1ffffffff", ok, last_sum); end
      checks++;
      if (res_q[r0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_result: got %0h expected ffffffff", res_q[r0]); end
      stub_fixed = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_midvector();
      int s0 = iss_q.size();
      int n0 = n_sum;
      int r_rst;
      int r1;
      bit ok;
      bit seen = 1'b0;
      stub_lat = 10;
      run_vector(1, 1'b0);
      for (int t = 0; t < 500; t++) begin
         if (iss_q.size() - s0 >= 6) begin seen = 1'b1; break; end
         tick();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_mid_reach: sixth issue not seen within bound"); end
      tick(2);
      reset_i = 1'b1;
      tick();
      checks++;
      if ({ready_o, busy_o, error_o, exp_data_valid_o, result_valid_o, sum_valid_o} !== 6'b0 ||
          sum_o !== '0 || result_o !== '0 || exp_data_o !== '0) begin
         errors++; $display("FAIL rst_mid_zero: flags %b sum %0h res %0h exp %0h expected all 0",
            {ready_o, busy_o, error_o, exp_data_valid_o, result_valid_o, sum_valid_o}, sum_o, result_o, exp_data_o);
      end
      r_rst = res_q.size();
      reset_i = 1'b0;
      spur_v = 1'b1; spur_d = 32'd5;
      tick();
      spur_v = 1'b0;
      tick(15);
      checks++;
      if (res_q.size() != r_rst || busy_o !== 1'b0 || n_sum != n0) begin
         errors++; $display("FAIL rst_mid_spurious: results +%0d busy %b sums +%0d expected 0 0 0",
            res_q.size() - r_rst, busy_o, n_sum - n0);
      end
      stub_lat = 3;
      r1 = res_q.size();
      run_vector(1, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || last_sum !== 33'd1055 || res_q.size() - r1 != N) begin
         errors++; $display("FAIL rst_mid_fresh: ok %b sum %0d results %0d expected 1 1055 %0d", ok, last_sum, res_q.size() - r1, N);
      end
      tick(2);
   endtask

   task automatic test_back_to_back();
      int n0 = n_sum;
      bit ok;
      stub_lat = 1;
      run_vector(1, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || last_sum !== 33'd1055) begin errors++; $display("FAIL b2b_first: ok %b sum %0d expected 1 1055", ok, last_sum); end
      run_vector(31, 1'b0);
      wait_done(ok);
      checks++;
      if (!ok || last_sum !== 33'd1355 || n_sum - n0 != 2) begin
         errors++; $display("FAIL b2b_second: ok %b sum %0d pulses %0d expected 1 1355 2", ok, last_sum, n_sum - n0);
      end
      tick(2);
   endtask

   initial begin
      reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
      test_reset();
      test_basic();
      test_gapped_load();
      test_timeout();
      test_timeout_boundary();
      test_saturation();
      test_reset_midvector();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/softmax_exp_scheduler.md
Name: softmax_exp_scheduler

Overview:
Sequencer that owns the exponent unit in the softmax COMPUTE stage. It captures one vector of number_of_data words from the upstream stream, then feeds the exp unit one element at a time with a single-cycle valid and waits for each result. Each exp result is forwarded to the normalisation stage and accumulated into a running sum, which is presented once the vector completes. A watchdog aborts the vector if the exp unit stops responding.

Parameters:
data_size, 32, width of input words and exp results
number_of_data, 10, elements per softmax vector (2..255)
sum_size, 40, accumulator width (>= data_size + ceil(log2(number_of_data)))
timeout_cycles, 64, max cycles in WAIT before abort (1..255)

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  synchronous reset, active-high
start_i  in  1  pulse: begin a new vector (honoured only in IDLE)
data_i  in  data_size  upstream element
data_valid_i  in  1  data_i qualifier
ready_o  out  1  high in LOAD only: element accepted when ready_o && data_valid_i
exp_data_o  out  data_size  operand to exp unit
exp_data_valid_o  out  1  one-cycle issue strobe to exp unit
exp_result_i  in  data_size  exp unit result
exp_result_valid_i  in  1  exp unit result strobe
result_o  out  data_size  forwarded exp result
result_valid_o  out  1  one-cycle strobe with result_o
sum_o  out  sum_size  sum of all exp results of the vector
sum_valid_o  out  1  one-cycle strobe, sum_o final
busy_o  out  1  high in any state except IDLE
error_o  out  1  sticky watchdog abort flag

Behaviour:
- Reset (reset_i=1 at rising edge): state IDLE; all outputs 0; wr_cnt, rd_cnt, timer, accumulator cleared; buffer contents don't-care. Reset mid-vector aborts with no strobes.
- All outputs registered.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: start_i -> LOAD next cycle; clears wr_cnt, rd_cnt, accumulator, sum_o, error_o. start_i in other states ignored.
- LOAD: ready_o=1. Accepted element written to buffer[wr_cnt], wr_cnt+1. On acceptance of element number_of_data-1 -> ISSUE. Gaps in data_valid_i allowed. data_valid_i outside LOAD ignored (not stored).
- ISSUE: exp_data_o <= buffer[rd_cnt], exp_data_valid_o=1 for exactly one cycle; timer cleared; -> WAIT. exp_data_o holds value until next issue.
- WAIT: timer+1 per cycle. On exp_result_valid_i: result_o <= exp_result_i, result_valid_o=1 for one cycle, accumulator += zero-extended exp_result_i, rd_cnt+1; if rd_cnt was number_of_data-1 -> DONE else -> ISSUE. A result arriving in the same cycle the timer reaches timeout_cycles is accepted (result has priority).
- Timeout: timer == timeout_cycles with no result -> error_o=1, -> IDLE; no sum_valid_o; partial result_valid_o strobes already emitted stand.
- exp_result_valid_i outside WAIT ignored.
- Accumulator saturates at all-ones of sum_size; never wraps.
- DONE: sum_o <= accumulator, sum_valid_o=1 one cycle, -> IDLE (busy_o low next cycle).
- Minimum vector latency, exp unit latency L: start -> LOAD 1 cycle, N accept cycles, then per element 1 (ISSUE) + L cycles, +1 DONE.
- Back-to-back: start_i in the cycle busy_o first reads 0 is accepted.

Test Plan:
- N=10, inputs 1..10 continuous, exp stub latency 3 returning input+100 -> result_o 101..110 in order, ten result_valid_o pulses, sum_o=1055 with one sum_valid_o, exactly one exp_data_valid_o per element.
- LOAD with data_valid_i toggled every other cycle, plus data_valid_i asserted in IDLE before start -> pre-start words dropped, buffer holds only the 10 accepted words.
- Stub stops after element 4, timeout_cycles=64 -> error_o=1 64 cycles after 5th issue, state IDLE, no sum_valid_o; next start_i clears error_o and a full vector completes correctly.
- Result arriving on timer==timeout_cycles cycle -> accepted, no error.
- Stub returns 32'hFFFFFFFF, sum_size=33 -> sum_o saturates at 33'h1FFFFFFFF.
- reset_i asserted during WAIT of element 6 -> all outputs 0 next cycle, spurious exp_result_valid_i afterwards ignored, fresh start completes normally.
